regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised register file with a per-register pending-write scoreboard. It generalises the single 16-bit two-read-port register into a WIDTH x DEPTH array with:
- one write port supporting full and half-word writes, for the load-low and load-high immediate instructions;
- two combinational read ports with optional write-before-read bypass;
- a busy bit per register that decode uses to stall on unresolved producers.

It sits between decode (issue/read side) and writeback (write side) in the pipelined CPU.

## Interface
- WIDTH, 16, bits per register; must be even and ≥ 2.
- DEPTH, 16, number of registers; power of two, ≥ 2. AW = $clog2(DEPTH) is a derived local parameter.
- clk  in  1  sole clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  WIDTH  writeback data.
- wr_mode  in  2  write mode:
  - 00: full write.
  - 01: low half only, bits [WIDTH/2-1:0].
  - 10: high half only, bits [WIDTH-1:WIDTH/2].
  - 11: treated as 00.
- iss_en  in  1  an instruction that will write iss_addr is issuing this cycle.
- iss_addr  in  AW  destination being claimed.
- rd_addr1, rd_addr2  in  AW  read addresses.
- rd_data1, rd_data2  out  WIDTH  read data.
- busy1, busy2  out  1  addressed register has an outstanding producer.
- wr_unclaimed  out  1  registered flag: the last write targeted a non-pending, nonzero register.

## Operation
Register 0:
- Reads as 0 and is never pending.
- Writes to it and issues to it are ignored and do not set wr_unclaimed.

Write:
- On the rising edge with wr_en=1 and wr_addr≠0, only the bits selected by wr_mode are updated, from the same bit positions of wr_data.
- Unselected bits hold their value.

Scoreboard (pend[DEPTH-1:0]):
- iss_en=1 sets pend[iss_addr].
- wr_en=1 clears pend[wr_addr].
- If iss_addr==wr_addr in the same cycle, the set wins: a new producer has claimed the register.
- A half write clears pend like a full write.

Read ports:
- rd_dataN = reg[rd_addrN] combinationally.
- busyN = pend[rd_addrN] combinationally, except as modified by bypass (see Configuration).
- busyN is never asserted for rd_addrN==0.
- Both ports may read the same address.

wr_unclaimed:
- Updated every edge.
- Equals wr_en && wr_addr≠0 && !pend[wr_addr], with pend sampled before the update.

## Timing
- Reset asserted: all registers = 0, pend = 0, wr_unclaimed = 0, immediately and without waiting for clk.
  - A write or issue in flight during reset is lost.
  - Outputs follow the cleared state combinationally.
- Write latency is 1 edge.
  - Without bypass, the new value is visible on the read ports the cycle after wr_en.
  - With bypass, it is visible in the same cycle.
- Issue latency is 1 edge: busy asserts the cycle after iss_en.
  - There is no same-cycle issue forwarding; decode handles back-to-back dependence itself.
- No handshake back-pressure: the block accepts one write and one issue every cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wr_en=1 and wr_addr==rd_addrN≠0, rd_dataN is the post-write merged value: new selected bits, old unselected bits.
  - busyN is 0 in that cycle unless iss_en claims the same address.
- REGFILE_BYPASS_EN undefined:
  - Read ports and busy show state before the edge.
  - The writer must allow one cycle before a dependent read.

## Test plan
- Reset mid-operation:
  1. Write 0xBEEF to r3, then issue r5.
  2. Assert rst between edges.
  3. Expect: rd_data(r3)=0, busy(r5)=0 and wr_unclaimed=0 immediately after rst asserts, before the next clk edge.
- Half writes:
  1. Full write 0x1234 to r4.
  2. wr_mode=01 with data 0x00AB.
  3. wr_mode=10 with data 0xCD00.
  4. Expect: r4 reads 0x12AB, then 0xCDAB.
- Register 0:
  1. Write 0xFFFF to r0 and issue r0.
  2. Expect: rd_data=0, busy=0, wr_unclaimed=0.
- Scoreboard:
  1. Issue r7.
  2. Expect: busy1=1 for rd_addr1=7 from the next cycle.
  3. Write r7 together with iss_en on r7.
  4. Expect: busy stays 1.
  5. Write r7 alone.
  6. Expect: busy=0 the following cycle.
- Bypass, with REGFILE_BYPASS_EN:
  1. Set r2=0x00FF and issue r2.
  2. Write r2 with 0xA500, wr_mode=10, while rd_addr1=rd_addr2=2.
  3. Expect: both ports read 0xA5FF and busy=0 in that cycle.
- Bypass, without REGFILE_BYPASS_EN:
  1. Repeat the bypass scenario.
  2. Expect: 0x00FF with busy=1 in the write cycle.
  3. Expect: 0xA5FF with busy=0 the next cycle.
- Unclaimed write:
  1. Write r9 with nothing issued.
  2. Expect: wr_unclaimed=1 for exactly one cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Purpose : WIDTH x DEPTH register file, one full/half-word write port, two
//           combinational read ports, and a per-register pending-write scoreboard.
// Latency : write and issue land on the next rising edge; reads are combinational.
//           With REGFILE_BYPASS_EN defined, a write is visible on the read ports
//           in the same cycle.
// Backpressure: none; one write and one issue are accepted every cycle.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   wr_en/addr/data     writeback port
//   wr_mode             00 full, 01 low half, 10 high half, 11 full
//   iss_en/iss_addr     decode claims iss_addr as a pending destination
//   rd_addr1/2          read addresses
//   rd_data1/2          read data (register 0 always reads 0)
//   busy1/2             addressed register has an outstanding producer
//   wr_unclaimed        registered: the last write hit a non-pending, nonzero register
//
// Optional feature macro: REGFILE_BYPASS_EN (write-before-read bypass).
module regfile_scoreboard #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [1:0]               wr_mode,
  input  logic                     iss_en,
  input  logic [$clog2(DEPTH)-1:0] iss_addr,
  input  logic [$clog2(DEPTH)-1:0] rd_addr1,
  input  logic [$clog2(DEPTH)-1:0] rd_addr2,
  output logic [WIDTH-1:0]         rd_data1,
  output logic [WIDTH-1:0]         rd_data2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     wr_unclaimed
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = WIDTH / 2;

  localparam logic [WIDTH-1:0] LO_MASK = {{(WIDTH - HW){1'b0}}, {HW{1'b1}}};
  localparam logic [WIDTH-1:0] HI_MASK = ~LO_MASK;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             wr_unclaimed_q;
  logic             wr_unclaimed_d;

  // Write qualification: register 0 is hard-wired and never takes a write.
  logic             wr_act;
  logic             iss_act;
  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] wr_merged;

  assign wr_act  = wr_en  && (wr_addr  != '0);
  assign iss_act = iss_en && (iss_addr != '0);

  always_comb begin
    wr_mask = '1;
    unique case (wr_mode)
      2'b01:   wr_mask = LO_MASK;
      2'b10:   wr_mask = HI_MASK;
      default: wr_mask = '1;
    endcase
  end

  // Post-write value of the target register: selected bits from wr_data,
  // the rest kept. Shared by the storage update and the bypass path.
  assign wr_merged = (mem_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);

  // --------------------------------------------------------------------------
  // Register array
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_act) begin
      mem_q[wr_addr] <= wr_merged;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard. Issue is applied after the write clear so a new producer
  // claiming the register in the same cycle keeps it pending.
  // --------------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    if (wr_en) begin
      pend_d[wr_addr] = 1'b0;
    end
    if (iss_en) begin
      pend_d[iss_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // pend_q is sampled before this edge's update.
  assign wr_unclaimed_d = wr_act && !pend_q[wr_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q         <= '0;
      wr_unclaimed_q <= 1'b0;
    end else begin
      pend_q         <= pend_d;
      wr_unclaimed_q <= wr_unclaimed_d;
    end
  end

  assign wr_unclaimed = wr_unclaimed_q;

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] arr_data1;
  logic [WIDTH-1:0] arr_data2;
  logic             arr_busy1;
  logic             arr_busy2;

  assign arr_data1 = (rd_addr1 == '0) ? '0 : mem_q[rd_addr1];
  assign arr_data2 = (rd_addr2 == '0) ? '0 : mem_q[rd_addr2];
  assign arr_busy1 = (rd_addr1 != '0) && pend_q[rd_addr1];
  assign arr_busy2 = (rd_addr2 != '0) && pend_q[rd_addr2];

`ifdef REGFILE_BYPASS_EN
  // A write landing this cycle resolves the producer; only a fresh claim of
  // the same register in the same cycle keeps the reader stalled.
  logic hit1;
  logic hit2;

  assign hit1 = wr_act && (wr_addr == rd_addr1);
  assign hit2 = wr_act && (wr_addr == rd_addr2);

  assign rd_data1 = hit1 ? wr_merged : arr_data1;
  assign rd_data2 = hit2 ? wr_merged : arr_data2;
  assign busy1    = hit1 ? (iss_act && (iss_addr == rd_addr1)) : arr_busy1;
  assign busy2    = hit2 ? (iss_act && (iss_addr == rd_addr2)) : arr_busy2;
`else
  assign rd_data1 = arr_data1;
  assign rd_data2 = arr_data2;
  assign busy1    = arr_busy1;
  assign busy2    = arr_busy2;
`endif

endmodule
